// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and constants for the radix-2 butterfly sequencer
package fft_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      SUM,
      OUT
   } state_t;

   localparam int DEF_N = 16;

   // Twiddles are Q1.(n-1): one sign bit, n-1 fraction bits.
   function automatic int tw_frac(input int n);
      return n - 1;
   endfunction

   function automatic int sat_max(input int n);
      return (1 << (n - 1)) - 1;
   endfunction

   function automatic int sat_min(input int n);
      return -(1 << (n - 1));
   endfunction

endpackage

// File: rtl/fft_bfly_seq_if.sv
// rtl/fft_bfly_seq_if.sv - operand, multiplier and result signals of the butterfly sequencer
interface fft_bfly_seq_if
   import fft_pkg::*;
#(
   parameter int N = DEF_N
) ();

   logic                  in_valid;
   logic                  in_ready;
   logic signed [N-1:0]   xr, xi, yr, yi;
   logic signed [N-1:0]   wr, wi;
   logic                  mul_ld;
   logic signed [N-1:0]   mul_m, mul_r;
   logic                  mul_valid;
   logic signed [2*N-1:0] mul_p;
   logic                  out_valid;
   logic                  out_ready;
   logic signed [N-1:0]   ar, ai, br, bi;
   logic                  out_sat;

   modport master (
      output in_valid, xr, xi, yr, yi, wr, wi,
      input  in_ready,
      input  mul_ld, mul_m, mul_r,
      output mul_valid, mul_p,
      input  out_valid, ar, ai, br, bi, out_sat,
      output out_ready
   );

   modport slave (
      input  in_valid, xr, xi, yr, yi, wr, wi,
      output in_ready,
      output mul_ld, mul_m, mul_r,
      input  mul_valid, mul_p,
      output out_valid, ar, ai, br, bi, out_sat,
      input  out_ready
   );

endinterface

// File: rtl/fft_round_sat.sv
// rtl/fft_round_sat.sv - Q1.(N-1) rescale of a twiddle product, add/sub to X, shift and saturate
// Round-half-up of the product is enabled by defining FFT_BFLY_ROUND_EN; truncation otherwise.
module fft_round_sat
   import fft_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int SCALE = 1
) (
   input  logic signed [N-1:0] i_x,
   input  logic signed [2*N:0] i_t,
   input  logic                i_sub,
   output logic signed [N-1:0] o_y,
   output logic                o_sat
);

   localparam int FRAC = tw_frac(N);
   localparam logic signed [N+2:0] HI = (N+3)'(sat_max(N));
   localparam logic signed [N+2:0] LO = (N+3)'(sat_min(N));
`ifdef FFT_BFLY_ROUND_EN
   localparam logic signed [2*N:0] RND = (2*N+1)'(1) << (FRAC - 1);
`else
   localparam logic signed [2*N:0] RND = '0;
`endif

   logic signed [2*N:0] w_t_rnd;
   logic signed [N+1:0] w_tq;
   logic signed [N+2:0] w_x_ext;
   logic signed [N+2:0] w_tq_ext;
   logic signed [N+2:0] w_sum;
   logic signed [N+2:0] w_shf;

   assign w_t_rnd  = i_t + RND;
   // Taking the upper N+2 bits is the arithmetic shift by FRAC.
   assign w_tq     = w_t_rnd[FRAC+N+1:FRAC];
   assign w_x_ext  = {{3{i_x[N-1]}}, i_x};
   assign w_tq_ext = {w_tq[N+1], w_tq};
   assign w_sum    = i_sub ? (w_x_ext - w_tq_ext) : (w_x_ext + w_tq_ext);
   assign w_shf    = w_sum >>> SCALE;

   always_comb begin
      o_y   = w_shf[N-1:0];
      o_sat = 1'b0;
      if (w_shf > HI) begin
         o_y   = HI[N-1:0];
         o_sat = 1'b1;
      end else if (w_shf < LO) begin
         o_y   = LO[N-1:0];
         o_sat = 1'b1;
      end
   end

endmodule

// File: rtl/fft_bfly_seq.sv
// rtl/fft_bfly_seq.sv - radix-2 DIT butterfly sharing one external iterative multiplier
// Optional rounding: FFT_BFLY_ROUND_EN (see fft_round_sat).
module fft_bfly_seq
   import fft_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int SCALE = 1
) (
   input  logic          Clk,
   input  logic          Rst,
   fft_bfly_seq_if.slave bus
);

   state_t                r_state, w_next;
   logic [1:0]            r_k;
   logic signed [N-1:0]   r_xr, r_xi, r_yr, r_yi, r_wr, r_wi;
   logic signed [2*N-1:0] r_p [4];
   logic signed [N-1:0]   r_ar, r_ai, r_br, r_bi;
   logic                  r_sat;

   logic signed [2*N:0]   w_tr, w_ti;
   logic signed [N-1:0]   w_ar, w_ai, w_br, w_bi;
   logic [3:0]            w_sat;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (bus.in_valid) w_next = ISSUE;
         ISSUE:   w_next = WAIT;
         WAIT:    if (bus.mul_valid) w_next = (r_k == 2'd3) ? SUM : ISSUE;
         SUM:     w_next = OUT;
         OUT:     if (bus.out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Operand pair k stays selected through ISSUE and WAIT, so mul_m/mul_r hold until mul_valid.
   always_comb begin
      bus.in_ready  = (r_state == IDLE);
      bus.mul_ld    = (r_state == ISSUE);
      bus.out_valid = (r_state == OUT);
      bus.mul_m     = r_yr;
      bus.mul_r     = r_wr;
      unique case (r_k)
         2'd0: begin bus.mul_m = r_yr; bus.mul_r = r_wr; end
         2'd1: begin bus.mul_m = r_yi; bus.mul_r = r_wi; end
         2'd2: begin bus.mul_m = r_yr; bus.mul_r = r_wi; end
         2'd3: begin bus.mul_m = r_yi; bus.mul_r = r_wr; end
         default: ;
      endcase
      bus.ar      = r_ar;
      bus.ai      = r_ai;
      bus.br      = r_br;
      bus.bi      = r_bi;
      bus.out_sat = r_sat;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_k   <= '0;
         r_xr  <= '0;
         r_xi  <= '0;
         r_yr  <= '0;
         r_yi  <= '0;
         r_wr  <= '0;
         r_wi  <= '0;
         for (int i = 0; i < 4; i++) r_p[i] <= '0;
         r_ar  <= '0;
         r_ai  <= '0;
         r_br  <= '0;
         r_bi  <= '0;
         r_sat <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_xr <= bus.xr;
                  r_xi <= bus.xi;
                  r_yr <= bus.yr;
                  r_yi <= bus.yi;
                  r_wr <= bus.wr;
                  r_wi <= bus.wi;
                  r_k  <= '0;
               end
            end
            WAIT: begin
               if (bus.mul_valid) begin
                  r_p[r_k] <= bus.mul_p;
                  if (r_k != 2'd3) r_k <= r_k + 2'd1;
               end
            end
            SUM: begin
               r_ar  <= w_ar;
               r_ai  <= w_ai;
               r_br  <= w_br;
               r_bi  <= w_bi;
               r_sat <= |w_sat;
            end
            default: ;
         endcase
      end
   end

   // Real and imaginary parts of W*Y at full precision.
   assign w_tr = {r_p[0][2*N-1], r_p[0]} - {r_p[1][2*N-1], r_p[1]};
   assign w_ti = {r_p[2][2*N-1], r_p[2]} + {r_p[3][2*N-1], r_p[3]};

   fft_round_sat #(.N(N), .SCALE(SCALE)) u_rs_ar (
      .i_x(r_xr), .i_t(w_tr), .i_sub(1'b0), .o_y(w_ar), .o_sat(w_sat[0])
   );
   fft_round_sat #(.N(N), .SCALE(SCALE)) u_rs_ai (
      .i_x(r_xi), .i_t(w_ti), .i_sub(1'b0), .o_y(w_ai), .o_sat(w_sat[1])
   );
   fft_round_sat #(.N(N), .SCALE(SCALE)) u_rs_br (
      .i_x(r_xr), .i_t(w_tr), .i_sub(1'b1), .o_y(w_br), .o_sat(w_sat[2])
   );
   fft_round_sat #(.N(N), .SCALE(SCALE)) u_rs_bi (
      .i_x(r_xi), .i_t(w_ti), .i_sub(1'b1), .o_y(w_bi), .o_sat(w_sat[3])
   );

endmodule

// File: tb/tb_fft_bfly_seq.sv
// tb/tb_fft_bfly_seq.sv - bench for fft_bfly_seq: SCALE=1 and SCALE=0 instances driven in lockstep
module tb_fft_bfly_seq;
   import fft_pkg::*;

   localparam int N   = 16;
   localparam int L   = (N + 1) / 2 + 1;
   localparam int LAT = 4 * (L + 1) + 2;
`ifdef FFT_BFLY_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   ld_err = 0;

   fft_bfly_seq_if #(.N(N)) if1 ();
   fft_bfly_seq_if #(.N(N)) if0 ();

   fft_bfly_seq #(.N(N), .SCALE(1)) u_dut1 (.Clk(Clk), .Rst(Rst), .bus(if1.slave));
   fft_bfly_seq #(.N(N), .SCALE(0)) u_dut0 (.Clk(Clk), .Rst(Rst), .bus(if0.slave));

   always #5 Clk = ~Clk;

   // Multiplier stand-ins: exact product, mul_valid sampled L edges after mul_ld.
   logic signed [2*N-1:0] mp1, mp0;
   logic                  mv1, mv0;
   int                    mc1, mc0;
   logic                  inj = 1'b0;

   always @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         mc1 <= 0; mv1 <= 1'b0; mp1 <= '0;
      end else begin
         mv1 <= 1'b0;
         if (if1.mul_ld) begin
            if (mc1 != 0 || mv1) ld_err <= ld_err + 1;
            mc1 <= L - 1;
            mp1 <= if1.mul_m * if1.mul_r;
         end else if (mc1 != 0) begin
            mc1 <= mc1 - 1;
            if (mc1 == 1) mv1 <= 1'b1;
         end
      end
   end

   always @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         mc0 <= 0; mv0 <= 1'b0; mp0 <= '0;
      end else begin
         mv0 <= 1'b0;
         if (if0.mul_ld) begin
            if (mc0 != 0 || mv0) ld_err <= ld_err + 1;
            mc0 <= L - 1;
            mp0 <= if0.mul_m * if0.mul_r;
         end else if (mc0 != 0) begin
            mc0 <= mc0 - 1;
            if (mc0 == 1) mv0 <= 1'b1;
         end
      end
   end

   assign if1.mul_valid = mv1 | inj;
   assign if1.mul_p     = mp1;
   assign if0.mul_valid = mv0 | inj;
   assign if0.mul_p     = mp0;

   logic [15:0] obs1 [4];
   logic [15:0] obs0 [4];
   logic        osat1, osat0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic longint clamp16(input longint v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Butterfly computed directly from the arithmetic definition.
   task automatic ref_bfly(input logic signed [15:0] xr, xi, yr, yi, wr, wi, input int scale,
                           output logic [15:0] e [4], output logic sat);
      longint tr, ti, rnd, v [4];
      rnd = ROUND ? (64'sd1 <<< 14) : 64'sd0;
      tr  = longint'(yr) * longint'(wr) - longint'(yi) * longint'(wi);
      ti  = longint'(yr) * longint'(wi) + longint'(yi) * longint'(wr);
      tr  = (tr + rnd) >>> 15;
      ti  = (ti + rnd) >>> 15;
      v[0] = (longint'(xr) + tr) >>> scale;
      v[1] = (longint'(xi) + ti) >>> scale;
      v[2] = (longint'(xr) - tr) >>> scale;
      v[3] = (longint'(xi) - ti) >>> scale;
      sat = 1'b0;
      for (int i = 0; i < 4; i++) begin
         e[i] = 16'(clamp16(v[i]));
         if (clamp16(v[i]) != v[i]) sat = 1'b1;
      end
   endtask

   task automatic drive(input logic signed [15:0] xr, xi, yr, yi, wr, wi, input logic v);
      if1.xr = xr; if1.xi = xi; if1.yr = yr; if1.yi = yi; if1.wr = wr; if1.wi = wi;
      if0.xr = xr; if0.xi = xi; if0.yr = yr; if0.yi = yi; if0.wr = wr; if0.wi = wi;
      if1.in_valid = v;
      if0.in_valid = v;
   endtask

   task automatic set_ready(input logic r);
      if1.out_ready = r;
      if0.out_ready = r;
   endtask

   task automatic cmp_out(input string tag, input logic [15:0] e1 [4], input logic s1,
                          input logic [15:0] e0 [4], input logic s0);
      chk({tag, "_ar1"}, if1.ar, e1[0]);
      chk({tag, "_ai1"}, if1.ai, e1[1]);
      chk({tag, "_br1"}, if1.br, e1[2]);
      chk({tag, "_bi1"}, if1.bi, e1[3]);
      chk({tag, "_sat1"}, 16'(if1.out_sat), 16'(s1));
      chk({tag, "_ar0"}, if0.ar, e0[0]);
      chk({tag, "_ai0"}, if0.ai, e0[1]);
      chk({tag, "_br0"}, if0.br, e0[2]);
      chk({tag, "_bi0"}, if0.bi, e0[3]);
      chk({tag, "_sat0"}, 16'(if0.out_sat), 16'(s0));
   endtask

   task automatic run_txn(input string tag, input logic signed [15:0] xr, xi, yr, yi, wr, wi,
                          input int hold);
      logic [15:0] e1 [4];
      logic [15:0] e0 [4];
      logic        s1, s0;
      int          cyc;
      ref_bfly(xr, xi, yr, yi, wr, wi, 1, e1, s1);
      ref_bfly(xr, xi, yr, yi, wr, wi, 0, e0, s0);
      @(negedge Clk);
      chk({tag, "_in_ready"}, 16'(if1.in_ready), 16'd1);
      drive(xr, xi, yr, yi, wr, wi, 1'b1);
      @(negedge Clk);
      drive(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
      cyc = 1;
      while (!if1.out_valid && cyc < 300) begin
         @(negedge Clk);
         cyc++;
      end
      chk({tag, "_latency"}, 16'(cyc), 16'(LAT));
      chk({tag, "_out_valid0"}, 16'(if0.out_valid), 16'd1);
      cmp_out(tag, e1, s1, e0, s0);
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            inj = (i == hold / 2);
            @(negedge Clk);
         end
         inj = 1'b0;
         chk({tag, "_bp_in_ready"}, 16'(if1.in_ready), 16'd0);
         chk({tag, "_bp_out_valid"}, 16'(if1.out_valid), 16'd1);
         cmp_out({tag, "_bp"}, e1, s1, e0, s0);
      end
      obs1[0] = if1.ar; obs1[1] = if1.ai; obs1[2] = if1.br; obs1[3] = if1.bi;
      obs0[0] = if0.ar; obs0[1] = if0.ai; obs0[2] = if0.br; obs0[3] = if0.bi;
      osat1 = if1.out_sat;
      osat0 = if0.out_sat;
      set_ready(1'b1);
      @(negedge Clk);
      set_ready(1'b0);
      chk({tag, "_done_out_valid"}, 16'(if1.out_valid), 16'd0);
      chk({tag, "_done_in_ready"}, 16'(if1.in_ready), 16'd1);
   endtask

   function automatic logic signed [15:0] rnd16();
      int unsigned r;
      r = $urandom_range(0, 7);
      if (r == 0) return 16'sh8000;
      if (r == 1) return 16'sh7FFF;
      return 16'($urandom);
   endfunction

   initial begin
      drive(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
      set_ready(1'b0);
      Rst = 1'b1;
      repeat (3) @(negedge Clk);
      chk("rst_in_ready", 16'(if1.in_ready), 16'd1);
      chk("rst_mul_ld", 16'(if1.mul_ld), 16'd0);
      chk("rst_mul_m", if1.mul_m, 16'd0);
      chk("rst_mul_r", if1.mul_r, 16'd0);
      chk("rst_out_valid", 16'(if1.out_valid), 16'd0);
      chk("rst_ar", if1.ar, 16'd0);
      chk("rst_bi", if1.bi, 16'd0);
      chk("rst_out_sat", 16'(if1.out_sat), 16'd0);
      chk("rst_out_valid0", 16'(if0.out_valid), 16'd0);
      Rst = 1'b0;

      run_txn("tw_m1", 16'sh1000, 16'sh0000, 16'sh0400, 16'sh0200, 16'sh8000, 16'sh0000, 0);
      chk("tw_m1_ar_const", obs1[0], 16'h0600);
      chk("tw_m1_ai_const", obs1[1], 16'hFF00);
      chk("tw_m1_br_const", obs1[2], 16'h0A00);
      chk("tw_m1_bi_const", obs1[3], 16'h0100);
      chk("tw_m1_sat_const", 16'(osat1), 16'd0);

      run_txn("tw_mj", 16'sh0000, 16'sh0000, 16'sh0400, 16'sh0200, 16'sh0000, 16'sh8000, 0);
      chk("tw_mj_ar_const", obs1[0], 16'h0100);
      chk("tw_mj_ai_const", obs1[1], 16'hFE00);
      chk("tw_mj_br_const", obs1[2], 16'hFF00);
      chk("tw_mj_bi_const", obs1[3], 16'h0200);

      run_txn("sat", 16'sh0000, 16'sh0000, 16'sh8000, 16'sh0000, 16'sh8000, 16'sh0000, 0);
      chk("sat_ar_const", obs0[0], 16'h7FFF);
      chk("sat_br_const", obs0[2], 16'h8000);
      chk("sat_flag_const", 16'(osat0), 16'd1);

      run_txn("sat_s1", 16'sh7FFF, 16'sh0000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh7FFF, 0);
      chk("sat_s1_ar_const", obs1[0], 16'h7FFF);
      chk("sat_s1_flag_const", 16'(osat1), 16'd1);

      run_txn("rnd", 16'sh0000, 16'sh0000, 16'sh0001, 16'sh0000, 16'sh4000, 16'sh0000, 0);
      chk("rnd_ar_const", obs0[0], ROUND ? 16'h0001 : 16'h0000);

      run_txn("bp", rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 20);

      for (int t = 0; t < 8; t++)
         run_txn($sformatf("rand%0d", t), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 0);

      // Reset in the middle of the third product wait.
      @(negedge Clk);
      drive(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 1'b1);
      @(negedge Clk);
      drive(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
      repeat (2 * (L + 1) + 4) @(negedge Clk);
      chk("mid_in_ready_before", 16'(if1.in_ready), 16'd0);
      Rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", 16'(if1.in_ready), 16'd1);
      chk("mid_rst_out_valid", 16'(if1.out_valid), 16'd0);
      chk("mid_rst_mul_ld", 16'(if1.mul_ld), 16'd0);
      chk("mid_rst_in_ready0", 16'(if0.in_ready), 16'd1);
      @(negedge Clk);
      Rst = 1'b0;
      run_txn("post_rst", rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 0);
      run_txn("post_rst2", rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 0);

      chk("mul_ld_protocol", 16'(ld_err), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
